// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - shared defaults, state encoding and width helper for the ALU operand sequencer
package ula_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_OP_W  = 2;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_WAIT = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  // Bits needed to hold values 0..value-1, never less than one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/ula_btn_debounce.sv
// rtl/ula_btn_debounce.sv - two-flop synchronizer, counting debouncer and rising-edge pulse for one button
module ula_btn_debounce
  import ula_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  localparam int CW = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LIM = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // The count only advances while the synchronized input disagrees with the
  // accepted level; it stops at LIM where the new level is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      pulse <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt >= LIM) begin
        level <= sync2;
        cnt   <= '0;
        pulse <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ula_operand_sequencer.sv
// rtl/ula_operand_sequencer.sv - collects A, B and op from switches, waits on the ALU and captures C
module ula_operand_sequencer
  import ula_pkg::*;
#(
  parameter int WIDTH           = DEF_WIDTH,
  parameter int OP_W            = DEF_OP_W,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int ALU_LAT         = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_load,
  input  logic             btn_clr,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] alu_c,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic [2:0]       stage
);

  localparam int WCW = clog2(ALU_LAT + 1);

  state_t           state;
  logic [WCW-1:0]   wait_cnt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [OP_W-1:0]  op_reg;
  logic             load_p;
  logic             clr_p;

  ula_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_load),
    .pulse (load_p)
  );

  ula_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_db (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_clr),
    .pulse (clr_p)
  );

  // Clear wins over a load arriving on the same clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_A;
      wait_cnt     <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      op_reg       <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else if (clr_p) begin
      state        <= S_A;
      wait_cnt     <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      op_reg       <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        S_A: begin
          if (load_p) begin
            a_reg        <= sw;
            result_valid <= 1'b0;
            state        <= S_B;
          end
        end
        S_B: begin
          if (load_p) begin
            b_reg <= sw;
            state <= S_OP;
          end
        end
        S_OP: begin
          if (load_p) begin
            op_reg   <= sw[OP_W-1:0];
            wait_cnt <= WCW'(ALU_LAT);
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Presses here are dropped, not queued.
          if (wait_cnt == '0) begin
            result       <= alu_c;
            result_valid <= 1'b1;
            state        <= S_SHOW;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        S_SHOW: begin
          if (load_p) state <= S_A;
        end
        default: state <= S_A;
      endcase
    end
  end

  assign alu_a  = a_reg;
  assign alu_b  = b_reg;
  assign alu_op = op_reg;
  assign stage  = state;

endmodule
